// File: rtl/execute_div_seq.sv
// Multi-cycle restoring divider (divw/divwu) that borrows the shared execute_alu, one step per cycle.
// Optional build macro EXDIV_EARLY_OUT_EN: divide-by-zero / signed overflow skip straight to DONE.
module execute_div_seq #(
    parameter int ALU_OP_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic [31:0]         in_dividend,
    input  logic [31:0]         in_divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_quot,
    output logic [31:0]         out_rem,
    output logic                out_ov,
    output logic                busy,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [31:0]         alu_c,
    output logic                alu_ci,
    input  logic [31:0]         alu_out,
    input  logic                alu_co
);

    localparam logic [ALU_OP_W-1:0] EXOP_ALU_SUB_BA = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] EXOP_ALU_NEG_A  = ALU_OP_W'(5);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ABS_A = 3'd1;
    localparam logic [2:0] S_ABS_D = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_NEG_Q = 3'd4;
    localparam logic [2:0] S_NEG_R = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state;
    logic [4:0]  cnt;
    logic        sgn;
    logic        sa;
    logic        sd;
    logic        ov_pend;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] d;

    logic [31:0] s;
    logic        acc;
    logic        ov_now;

    // q starts as the dividend and shifts out one bit per step while quotient bits shift in.
    assign s      = {r[30:0], q[31]};
    assign acc    = alu_co | r[31];
    assign ov_now = (in_divisor == 32'd0) |
                    (in_signed & (in_dividend == 32'h8000_0000) & (in_divisor == 32'hFFFF_FFFF));

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            S_ABS_A: begin
                alu_op = EXOP_ALU_NEG_A;
                alu_a  = q;
            end
            S_ABS_D: begin
                alu_op = EXOP_ALU_NEG_A;
                alu_a  = d;
            end
            S_STEP: begin
                alu_op = EXOP_ALU_SUB_BA;
                alu_a  = d;
                alu_b  = s;
            end
            S_NEG_Q: begin
                alu_op = EXOP_ALU_NEG_A;
                alu_a  = q;
            end
            S_NEG_R: begin
                alu_op = EXOP_ALU_NEG_A;
                alu_a  = r;
            end
            default: ;
        endcase
    end

    assign alu_c     = '0;
    assign alu_ci    = 1'b0;
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_ov    = (state == S_DONE) & ov_pend;
    assign out_quot  = ((state == S_DONE) && !ov_pend) ? q : 32'd0;
    assign out_rem   = ((state == S_DONE) && !ov_pend) ? r : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sgn     <= 1'b0;
            sa      <= 1'b0;
            sd      <= 1'b0;
            ov_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sgn     <= in_signed;
                        sa      <= in_dividend[31] & in_signed;
                        sd      <= in_divisor[31] & in_signed;
                        ov_pend <= ov_now;
                        cnt     <= '0;
`ifdef EXDIV_EARLY_OUT_EN
                        if (ov_now)
                            state <= S_DONE;
                        else
                            state <= in_signed ? S_ABS_A : S_STEP;
`else
                        state   <= in_signed ? S_ABS_A : S_STEP;
`endif
                    end
                end
                S_ABS_A: state <= S_ABS_D;
                S_ABS_D: state <= S_STEP;
                S_STEP: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= sgn ? S_NEG_Q : S_DONE;
                end
                S_NEG_Q: state <= S_NEG_R;
                S_NEG_R: state <= S_DONE;
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; every result is gated by state==DONE.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    q <= in_dividend;
                    d <= in_divisor;
                    r <= '0;
                end
            end
            S_ABS_A: if (sa) q <= alu_out;
            S_ABS_D: if (sd) d <= alu_out;
            S_STEP: begin
                r <= acc ? alu_out : s;
                q <= {q[30:0], acc};
            end
            S_NEG_Q: if (sa ^ sd) q <= alu_out;
            S_NEG_R: if (sa) r <= alu_out;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_execute_div_seq.sv
// Bench for execute_div_seq: behavioural ALU model, vector table, scoreboard queue, corner sequences.
module tb_execute_div_seq;

    localparam int ALU_OP_W = 6;
    localparam logic [5:0] OP_SUB_BA = 6'h03;
    localparam logic [5:0] OP_NEG_A  = 6'h05;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] quot;
        logic [31:0] rem;
        bit          ov;
    } vec_t;

    typedef struct {
        logic [31:0] quot;
        logic [31:0] rem;
        bit          ov;
        int          lat;
        bit          sgn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_quot;
    logic [31:0] out_rem;
    logic        out_ov;
    logic        busy;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;
    logic        alu_ci;
    logic [31:0] alu_out;
    logic        alu_co;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    vec_t tv[9];

    always #5 clk = ~clk;

    execute_div_seq #(.ALU_OP_W(ALU_OP_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_ov(out_ov), .busy(busy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_co(alu_co)
    );

    // Shared ALU stand-in: SUB_BA is b + ~a + 1, so the carry out is the no-borrow flag.
    always_comb begin
        alu_out = '0;
        alu_co  = 1'b0;
        case (alu_op)
            OP_NEG_A:  alu_out = 32'd0 - alu_a;
            OP_SUB_BA: {alu_co, alu_out} = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input bit sgn, input bit ov);
`ifdef EXDIV_EARLY_OUT_EN
        if (ov) return 1;
`endif
        return sgn ? 37 : 33;
    endfunction

    function automatic logic [5:0] exp_op(input bit sgn, input int cyc);
        if (!sgn) return (cyc >= 1 && cyc <= 32) ? OP_SUB_BA : 6'h00;
        if (cyc <= 2)  return OP_NEG_A;
        if (cyc <= 34) return OP_SUB_BA;
        if (cyc <= 36) return OP_NEG_A;
        return 6'h00;
    endfunction

    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa_v;
        logic signed [31:0] sb_v;
        e.sgn = sgn;
        e.ov  = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.lat = exp_lat(sgn, e.ov);
        sa_v  = $signed(a);
        sb_v  = $signed(b);
        if (e.ov) begin
            e.quot = '0;
            e.rem  = '0;
        end else if (sgn) begin
            e.quot = sa_v / sb_v;
            e.rem  = sa_v % sb_v;
        end else begin
            e.quot = a / b;
            e.rem  = a % b;
        end
        return e;
    endfunction

    // Leaves the bench at the falling edge of the first cycle after acceptance.
    task automatic send(input bit sgn, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clk);
        chk("in_ready_before_req", in_ready, 1);
        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic collect(input bit release_now);
        exp_t e;
        int cyc;
        int op_bad;
        e = sb.pop_front();
        cyc = 1;
        op_bad = 0;
        while (!out_valid && cyc < 200) begin
            if (alu_op !== exp_op(e.sgn, cyc)) op_bad++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, e.lat);
        chk("alu_op_seq", op_bad, 0);
        chk("quot", out_quot, e.quot);
        chk("rem", out_rem, e.rem);
        chk("ov", out_ov, e.ov);
        if (release_now) handshake();
    endtask

    initial begin
        exp_t e;
        tv[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tv[1] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        tv[2] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0};
        tv[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        tv[4] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0};
        tv[5] = '{1'b0, 32'd5,         32'd0,         32'd0,         32'd0,         1'b1};
        tv[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'd0,         1'b1};
        tv[7] = '{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0};
        tv[8] = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_out_quot", out_quot, 0);
        chk("rst_out_rem", out_rem, 0);
        chk("rst_out_ov", out_ov, 0);
        chk("alu_c_tied", alu_c, 0);
        chk("alu_ci_tied", alu_ci, 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            e.quot = tv[i].quot;
            e.rem  = tv[i].rem;
            e.ov   = tv[i].ov;
            e.sgn  = tv[i].sgn;
            e.lat  = exp_lat(tv[i].sgn, tv[i].ov);
            send(tv[i].sgn, tv[i].a, tv[i].b, e);
            collect(1'b1);
        end

        for (int i = 0; i < 6; i++) begin
            bit          sg;
            logic [31:0] a;
            logic [31:0] b;
            sg = 1'(i & 1);
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            send(sg, a, b, model(sg, a, b));
            collect(1'b1);
        end

        // Backpressure: result held while a competing request is presented.
        send(1'b0, 32'd100, 32'd7, model(1'b0, 32'd100, 32'd7));
        collect(1'b0);
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'd1234;
        in_divisor  = 32'd5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_quot", out_quot, 32'd14);
            chk("bp_rem", out_rem, 32'd2);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_busy_after", busy, 0);
        send(1'b0, 32'd9, 32'd3, model(1'b0, 32'd9, 32'd3));
        collect(1'b1);

        // Reset in the middle of STEP (counter 15) abandons the division.
        send(1'b0, 32'd100, 32'd7, model(1'b0, 32'd100, 32'd7));
        sb.delete(0);
        repeat (15) @(negedge clk);
        chk("mid_alu_op_step", alu_op, OP_SUB_BA);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        send(1'b0, 32'd100, 32'd7, model(1'b0, 32'd100, 32'd7));
        collect(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
